ped_walk_ctrl: RTL and testbench
================================

PED_WALK_CTRL -- requirements
Module: ped_walk_ctrl

Interface
REQ-001 Parameter WALK_CYCLES, default 6, sets the number of cycles steady WALK is shown.
REQ-002 Parameter FLASH_CYCLES, default 4, sets the number of cycles flashing DON'T-WALK is shown.
REQ-003 Parameter BLINK_DIV, default 1, sets the number of cycles per flash half-period.
REQ-004 Ports shall be: clk  in  1  single clock, all logic on the rising edge; rst  in  1  reset, asynchronous and active-high.
REQ-005 Ports shall be: color  in  light_t  current signal colour from the traffic controller (RED, YELLOW, GREEN); ped_req  in  1  raw, asynchronous pedestrian button.
REQ-006 Ports shall be: walk  out  1  WALK lamp; dont_walk  out  1  DON'T-WALK lamp.
REQ-007 Ports shall be: countdown  out  $clog2(FLASH_CYCLES+1)  remaining flash cycles; req_pending  out  1  request latched and awaiting service.

Function
REQ-008 The block shall pass ped_req through a 2-flop synchroniser and a rising-edge detector; one detected edge sets req_pending on the following clk edge.
REQ-009 Further button edges while req_pending=1 or in WALK/FLASH shall be ignored and shall not be queued.
REQ-010 The block shall register the previous color; red_entry = (color==RED && prev_color!=RED).
REQ-011 The FSM shall have states IDLE, WALK, FLASH.
REQ-012 IDLE->WALK shall occur on the clk edge where red_entry && req_pending; req_pending shall clear on the same edge.
REQ-013 A request made while color is already RED shall wait for the next red_entry.
REQ-014 The FSM shall stay in WALK for exactly WALK_CYCLES cycles, then enter FLASH.
REQ-015 The FSM shall stay in FLASH for exactly FLASH_CYCLES cycles, then enter IDLE.
REQ-016 In WALK: walk=1, dont_walk=0, countdown=FLASH_CYCLES.
REQ-017 In FLASH: walk=0; dont_walk=1 for the first BLINK_DIV cycles, then toggles every BLINK_DIV cycles; countdown = remaining FLASH cycles, from FLASH_CYCLES down to 1.
REQ-018 In IDLE: walk=0, dont_walk=1 steady, countdown=0.
REQ-019 Safety abort: if color!=RED in WALK or FLASH, the FSM shall enter IDLE on that edge, and walk=0/dont_walk=1 shall show from the next cycle.
REQ-020 An abort shall not re-set req_pending.
REQ-021 If a button edge and red_entry arrive on the same edge with req_pending=0, the block shall only latch req_pending; WALK is not entered until the next red_entry.
REQ-022 All outputs shall be registered.

Reset
REQ-023 Asserting rst shall force, asynchronously: IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0, synchroniser flops=0, prev_color=RED.
REQ-024 Reset asserted mid-WALK shall drop walk within the same cycle and discard any pending request.

Configuration
REQ-025 With macro PED_CHIRP_EN defined, the block shall add output chirp (1 bit): toggles every cycle in WALK, toggles every 2*BLINK_DIV cycles in FLASH, held 0 in IDLE and during reset.
REQ-026 Without PED_CHIRP_EN, the chirp port and its logic shall be absent; all other behaviour is identical.

Structure
REQ-027 Package traffic_pkg shall hold light_t (RED, YELLOW, GREEN) and ped_state_t (IDLE, WALK, FLASH); traffic and ped_walk_ctrl shall both import it.
REQ-028 The synchroniser plus edge detector shall be sub-module ped_req_sync (ports clk, rst, async_in, rise_pulse).
REQ-029 Cycle counters shall be sized from the parameters with $clog2 and shall have no wrap-around path.

Verification (defaults WALK_CYCLES=6, FLASH_CYCLES=4, BLINK_DIV=1)
REQ-030 Reset for 2 cycles, then idle -> walk=0, dont_walk=1, countdown=0, req_pending=0.
REQ-031 ped_req pulsed during GREEN -> req_pending=1 within 3 cycles; at next red_entry -> walk=1 for 6 cycles, then dont_walk 1,0,1,0 with countdown 4,3,2,1, then IDLE.
REQ-032 Three button pulses during one GREEN -> exactly one WALK/FLASH sequence; req_pending=0 afterwards.
REQ-033 color forced to GREEN on WALK cycle 3 -> walk=0, dont_walk=1 next cycle; FSM in IDLE; no later WALK without a new request.
REQ-034 Button pressed while color=RED -> no WALK in that RED phase; WALK starts at the following red_entry.
REQ-035 rst asserted mid-FLASH -> outputs reach reset values immediately; with PED_CHIRP_EN, chirp toggles every cycle in WALK and is 0 after reset.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller and the pedestrian walk controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2
    } ped_state_t;

endpackage

// File: rtl/ped_req_sync.sv
// Two-flop synchroniser for the raw pedestrian button followed by a rising-edge
// detector. rise_pulse is high for one cycle per synchronised 0->1 transition.
module ped_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    // Metastability chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise_pulse = sync & ~sync_d;

endmodule

// File: rtl/ped_walk_ctrl.sv
// Pedestrian WALK / flashing DON'T-WALK controller slaved to the traffic light.
// A latched button request is served at the next entry into RED; any non-RED
// colour during WALK or FLASH aborts straight back to IDLE.
// Optional feature: define PED_CHIRP_EN to add the audible 'chirp' output.
module ped_walk_ctrl
    import traffic_pkg::*;
#(
    parameter int WALK_CYCLES  = 6,
    parameter int FLASH_CYCLES = 4,
    parameter int BLINK_DIV    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  light_t                            color,
    input  logic                              ped_req,
    output logic                              walk,
    output logic                              dont_walk,
    output logic [$clog2(FLASH_CYCLES+1)-1:0] countdown,
    output logic                              req_pending
`ifdef PED_CHIRP_EN
    ,
    output logic                              chirp
`endif
);

    localparam int MAX_CYC = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int CD_W    = $clog2(FLASH_CYCLES + 1);
    localparam int BL_W    = $clog2(BLINK_DIV + 1);

    ped_state_t       state;
    ped_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [BL_W-1:0]  blink_cnt;
    logic [BL_W-1:0]  blink_cnt_nxt;
    logic             blink_ph;
    logic             blink_ph_nxt;
    logic             pend_nxt;
    logic             walk_nxt;
    logic             dont_walk_nxt;
    logic [CD_W-1:0]  countdown_nxt;
    light_t           prev_color;
    logic             red_entry;
    logic             btn_rise;

    ped_req_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (ped_req),
        .rise_pulse (btn_rise)
    );

    assign red_entry = (color == RED) && (prev_color != RED);

    // Previous colour; reset to RED so leaving reset in RED is not an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_color <= RED;
        else     prev_color <= color;
    end

    // State, counters and registered lamp outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b1;
            req_pending <= 1'b0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_ph    <= blink_ph_nxt;
            req_pending <= pend_nxt;
            walk        <= walk_nxt;
            dont_walk   <= dont_walk_nxt;
            countdown   <= countdown_nxt;
        end
    end

    // Next-state, request latch and next-output decode; counters restart at
    // every state entry so they never wrap.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = '0;
        blink_cnt_nxt = '0;
        blink_ph_nxt  = 1'b1;
        pend_nxt      = req_pending;
        walk_nxt      = 1'b0;
        dont_walk_nxt = 1'b1;
        countdown_nxt = '0;

        case (state)
            IDLE: begin
                if (red_entry && req_pending) begin
                    state_nxt = WALK;
                    pend_nxt  = 1'b0;
                end else if (btn_rise) begin
                    pend_nxt  = 1'b1;
                end
            end
            WALK: begin
                if (color != RED) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(WALK_CYCLES - 1)) begin
                    state_nxt = FLASH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FLASH: begin
                if (color != RED) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(FLASH_CYCLES - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
                        blink_cnt_nxt = '0;
                        blink_ph_nxt  = ~blink_ph;
                    end else begin
                        blink_cnt_nxt = blink_cnt + 1'b1;
                        blink_ph_nxt  = blink_ph;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            WALK: begin
                walk_nxt      = 1'b1;
                dont_walk_nxt = 1'b0;
                countdown_nxt = CD_W'(FLASH_CYCLES);
            end
            FLASH: begin
                dont_walk_nxt = blink_ph_nxt;
                countdown_nxt = CD_W'(FLASH_CYCLES) - CD_W'(cnt_nxt);
            end
            default: begin
                walk_nxt      = 1'b0;
                dont_walk_nxt = 1'b1;
                countdown_nxt = '0;
            end
        endcase
    end

`ifdef PED_CHIRP_EN
    localparam int CH_W = $clog2(2 * BLINK_DIV + 1);

    logic [CH_W-1:0] chirp_cnt;

    // Chirp: fast toggle in WALK, slow toggle (2*BLINK_DIV) in FLASH, silent in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chirp     <= 1'b0;
            chirp_cnt <= '0;
        end else begin
            case (state_nxt)
                WALK: begin
                    chirp     <= ~chirp;
                    chirp_cnt <= '0;
                end
                FLASH: begin
                    if (chirp_cnt == CH_W'(2 * BLINK_DIV - 1)) begin
                        chirp     <= ~chirp;
                        chirp_cnt <= '0;
                    end else begin
                        chirp_cnt <= chirp_cnt + 1'b1;
                    end
                end
                default: begin
                    chirp     <= 1'b0;
                    chirp_cnt <= '0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Directed bench for ped_walk_ctrl at default parameters (6 / 4 / 1).
module tb_ped_walk_ctrl;
    import traffic_pkg::*;

    logic       clk;
    logic       rst;
    light_t     color;
    logic       ped_req;
    logic       walk;
    logic       dont_walk;
    logic [2:0] countdown;
    logic       req_pending;
`ifdef PED_CHIRP_EN
    logic       chirp;
`endif

    int checks = 0;
    int errors = 0;

    ped_walk_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .color       (color),
        .ped_req     (ped_req),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .countdown   (countdown),
        .req_pending (req_pending)
`ifdef PED_CHIRP_EN
        ,
        .chirp       (chirp)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_cycle(input string tag, input int w, input int dw, input int cd);
        step();
        check({tag, ".walk"}, 32'(walk), w);
        check({tag, ".dont_walk"}, 32'(dont_walk), dw);
        check({tag, ".countdown"}, 32'(countdown), cd);
    endtask

    task automatic pulse();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step();
        step();
        step();
    endtask

    // Drive RED and check the complete WALK then FLASH then IDLE sequence.
    task automatic walk_sequence(input string tag);
        int flash_dw[4];
        int flash_cd[4];
        flash_dw = '{1, 0, 1, 0};
        flash_cd = '{4, 3, 2, 1};
        color = RED;
        for (int i = 0; i < 6; i++) expect_cycle({tag, ".walk"}, 1, 0, 4);
        check({tag, ".pend_clr"}, 32'(req_pending), 0);
        for (int i = 0; i < 4; i++) expect_cycle({tag, ".flash"}, 0, flash_dw[i], flash_cd[i]);
        expect_cycle({tag, ".idle"}, 0, 1, 0);
        check({tag, ".pend_after"}, 32'(req_pending), 0);
    endtask

    initial begin
        rst     = 1'b1;
        color   = RED;
        ped_req = 1'b0;

        // Reset for two cycles, then idle.
        step();
        step();
        check("rst.walk", 32'(walk), 0);
        check("rst.dont_walk", 32'(dont_walk), 1);
        check("rst.countdown", 32'(countdown), 0);
        check("rst.pend", 32'(req_pending), 0);
        rst = 1'b0;
        expect_cycle("idle0", 0, 1, 0);
        check("idle0.pend", 32'(req_pending), 0);

        // Single request during GREEN, served at the next red entry.
        color = GREEN;
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step();
        check("req.pend_early", 32'(req_pending), 0);
        step();
        check("req.pend_set", 32'(req_pending), 1);
        check("req.green_nowalk", 32'(walk), 0);
        walk_sequence("seq1");

        // Three presses in one GREEN give one sequence, nothing queued.
        color = GREEN;
        step();
        pulse();
        pulse();
        pulse();
        check("multi.pend", 32'(req_pending), 1);
        walk_sequence("seq3");
        color = GREEN;
        step();
        step();
        color = RED;
        for (int i = 0; i < 8; i++) expect_cycle("multi.noqueue", 0, 1, 0);

        // Safety abort: GREEN during WALK.
        color = GREEN;
        step();
        pulse();
        color = RED;
        for (int i = 0; i < 3; i++) expect_cycle("abort.walk", 1, 0, 4);
        color = GREEN;
        expect_cycle("abort.drop", 0, 1, 0);
        check("abort.pend", 32'(req_pending), 0);
        step();
        color = RED;
        for (int i = 0; i < 8; i++) expect_cycle("abort.norewalk", 0, 1, 0);

        // Request while already RED waits for the following red entry.
        pulse();
        check("redreq.pend", 32'(req_pending), 1);
        for (int i = 0; i < 4; i++) expect_cycle("redreq.wait", 0, 1, 0);
        check("redreq.pend_hold", 32'(req_pending), 1);
        color = GREEN;
        step();
        step();
        walk_sequence("seq_red");

        // Button edge coincides with red entry while nothing pending: latch only.
        color = GREEN;
        step();
        step();
        ped_req = 1'b1;
        step();
        step();
        ped_req = 1'b0;
        color = RED;
        step();
        check("coinc.walk", 32'(walk), 0);
        check("coinc.pend", 32'(req_pending), 1);
        for (int i = 0; i < 3; i++) expect_cycle("coinc.wait", 0, 1, 0);
        color = GREEN;
        step();
        step();
        walk_sequence("seq_coinc");

        // Asynchronous reset mid-FLASH (on a dark half, countdown 3).
        color = GREEN;
        step();
        pulse();
        color = RED;
        for (int i = 0; i < 6; i++) expect_cycle("rstf.walk", 1, 0, 4);
        expect_cycle("rstf.flash0", 0, 1, 4);
        expect_cycle("rstf.flash1", 0, 0, 3);
        rst = 1'b1;
        #1;
        check("rstf.walk", 32'(walk), 0);
        check("rstf.dont_walk", 32'(dont_walk), 1);
        check("rstf.countdown", 32'(countdown), 0);
        check("rstf.pend", 32'(req_pending), 0);
        step();
        rst = 1'b0;
        expect_cycle("rstf.after", 0, 1, 0);

        // Asynchronous reset mid-WALK drops walk immediately.
        color = GREEN;
        step();
        pulse();
        color = RED;
        for (int i = 0; i < 2; i++) expect_cycle("rstw.walk", 1, 0, 4);
        rst = 1'b1;
        #1;
        check("rstw.walk", 32'(walk), 0);
        check("rstw.dont_walk", 32'(dont_walk), 1);
        check("rstw.countdown", 32'(countdown), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) expect_cycle("rstw.after", 0, 1, 0);

        // Reset discards a latched but unserved request.
        color = GREEN;
        step();
        pulse();
        check("rstp.pend_set", 32'(req_pending), 1);
        rst = 1'b1;
        #1;
        check("rstp.pend_clr", 32'(req_pending), 0);
        step();
        rst = 1'b0;
        step();
        color = RED;
        for (int i = 0; i < 4; i++) expect_cycle("rstp.nowalk", 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
